mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch requester and the data-memory (load/store) requester of the 5-stage core.
- Data accesses have priority by default. A starvation counter forces a fetch grant after STARVE_MAX consecutive denied fetch cycles.
- Read data returns one cycle after grant, with a per-requester rvalid.
- Sits between program_counter/instruction fetch, the MEM stage, and the unified RAM macro.

Parameters:
- ADDR_W, 32, byte address width of both requesters and the RAM port.
- DATA_W, 32, data word width.
- STARVE_MAX, 4, consecutive denied fetch-request cycles before fetch is forced ahead of data (range 1..15).
- CNT_W, 4, starvation counter width; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 resets)
- if_req  in  1  fetch read request; held with stable if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (registered)
- if_rdata  out  DATA_W  fetch read data
- dm_req  in  1  data request; held with stable fields until dm_gnt
- dm_we  in  1  1=store, 0=load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_rvalid  out  1  dm_rdata valid; loads only (registered)
- dm_rdata  out  DATA_W  load data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read with mem_en=1 and mem_we=0
- fetch_stall  out  1  if_req && !if_gnt; OR'd into the hazard unit's fetch stall

Behaviour:
- Reset (rst==0 at posedge):
  - mode=ARB_DM; starve_cnt=0; rsp_owner=NONE.
  - if_rvalid=0, dm_rvalid=0, if_rdata=0, dm_rdata=0.
- While rst==0, all combinational outputs are forced to 0: if_gnt, dm_gnt, mem_en, mem_we, mem_addr, mem_wdata, fetch_stall.
- Mode FSM:
  - ARB_DM (default): dm_req wins. Otherwise if_req wins.
  - FORCE_IF: if_req wins unconditionally. Otherwise dm_req wins.
  - ARB_DM -> FORCE_IF when a posedge sees if_req && !if_gnt and starve_cnt==STARVE_MAX-1.
  - FORCE_IF -> ARB_DM on the first posedge with if_gnt=1.
  - FORCE_IF -> ARB_DM if if_req drops without a grant.
- starve_cnt:
  - Increments at each posedge with if_req && !if_gnt; saturates at STARVE_MAX-1.
  - Clears on if_gnt or !if_req.
- Grants:
  - At most one of if_gnt and dm_gnt is high per cycle.
  - mem_en = if_gnt | dm_gnt.
  - Address, write enable and write data are muxed from the winner; mem_we = dm_gnt & dm_we.
  - Idle cycles: mem_en=0 and mem_addr/mem_wdata=0.
- Response path, 1-cycle latency:
  - rsp_owner is registered at posedge: IF if if_gnt, DM if (dm_gnt && !dm_we), else NONE.
  - if_rvalid = (rsp_owner==IF) and if_rdata = mem_rdata, both registered in the cycle after the RAM returns data. Total latency: grant at cycle N, rvalid at N+2.
  - dm_rvalid/dm_rdata follow the same rule for rsp_owner==DM.
  - rdata holds its last value when rvalid=0.
- Stores: no response. Write completes at the grant edge.
- Back-to-back:
  - A new grant may issue every cycle; responses stay in order.
  - Two responses in flight are allowed. The pipeline holds owner at stages N+1 and N+2.
- Simultaneous requests:
  - In ARB_DM, fetch is denied up to STARVE_MAX cycles, then granted exactly once.
  - After that grant, data priority returns.
- Reset mid-operation: in-flight responses are discarded, with no rvalid after the reset edge. Counter and mode clear.
- Requester protocol violations are undefined, e.g. dropping req or changing addr before grant. The bench flags them; the RTL does not check them.

Decomposition:
- Shared package mem_arb_pkg: typedef enum logic {ARB_DM, FORCE_IF} arb_mode_t; typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} rsp_owner_t; localparam RSP_LAT=2.
- One natural sub-module, mem_arb_rsp_pipe: the owner/data delay pipeline producing the rvalid/rdata pairs.
- Arbitration and FSM stay in the top module.

Test Plan:
- Reset: hold rst=0 for 10 cycles with both reqs high -> all grants/rvalid 0. Release -> first cycle dm_gnt=1 and if_gnt=0.
- Fetch only: if_req at addr 0x00,0x04,0x08 on consecutive cycles, RAM preloaded with 0x11,0x22,0x33 -> if_gnt each cycle; if_rvalid two cycles later with data 0x11,0x22,0x33 in order.
- Store then load: dm store 0xDEADBEEF at 0x40, then load 0x40 -> dm_rvalid=1 with 0xDEADBEEF two cycles after the load grant; no dm_rvalid for the store.
- Starvation, STARVE_MAX=4: both reqs high continuously -> dm_gnt for 4 cycles, if_gnt on cycle 5, dm_gnt resumes on cycle 6; fetch_stall high during cycles 1-4.
- Mixed response ordering: alternate fetch 0x08 and load 0x80 grants on consecutive cycles -> if_rvalid and dm_rvalid pulse in grant order with the correct data; never both in the same cycle.
- Reset mid-flight: grant load 0x80, assert rst=0 the next cycle -> dm_rvalid stays 0; after release starve_cnt=0 and mode=ARB_DM.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the instruction/data memory port arbiter.
//   arb_mode_t   : arbitration mode (data-first, or fetch forced ahead)
//   rsp_owner_t  : which requester owns a read response in flight
//   RSP_LAT      : cycles from grant to rvalid (grant at N, rvalid at N+2)
//   rsp_owner_of : maps this cycle's grant to the owner of its response
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic {
      ARB_DM   = 1'b0,
      FORCE_IF = 1'b1
   } arb_mode_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } rsp_owner_t;

   localparam int RSP_LAT = 2;

   // Stores produce no response, so only fetches and loads claim an owner.
   function automatic rsp_owner_t rsp_owner_of(input logic if_gnt,
                                                input logic dm_gnt,
                                                input logic dm_we);
      rsp_owner_t owner;
      owner = OWN_NONE;
      if (if_gnt) begin
         owner = OWN_IF;
      end else if (dm_gnt && !dm_we) begin
         owner = OWN_DM;
      end
      return owner;
   endfunction

endpackage

// File: rtl/mem_arb_rsp_pipe.sv
// -----------------------------------------------------------------------------
// mem_arb_rsp_pipe
// Carries the owner of each granted read down a two-stage pipeline so the RAM
// read data (valid the cycle after the grant) is steered to the right
// requester and registered, giving rvalid two cycles after the grant.
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   owner_in              : owner of the access granted this cycle
//   mem_rdata             : RAM read data (valid one cycle after a read grant)
//   if_rvalid / if_rdata  : fetch response (registered)
//   dm_rvalid / dm_rdata  : load response (registered)
//   dbg_owner             : owner currently waiting on the RAM (stage N+1)
// -----------------------------------------------------------------------------
module mem_arb_rsp_pipe
   import mem_arb_pkg::*;
#(
   parameter int DATA_W = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  rsp_owner_t        owner_in,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output rsp_owner_t        dbg_owner
);

   // Stage N+1: owner of the read the RAM is returning this cycle.
   rsp_owner_t        owner_d,     owner_q;
   // Stage N+2: registered response per requester.
   logic              if_rvalid_d, if_rvalid_q;
   logic              dm_rvalid_d, dm_rvalid_q;
   logic [DATA_W-1:0] if_rdata_d,  if_rdata_q;
   logic [DATA_W-1:0] dm_rdata_d,  dm_rdata_q;

   always_comb begin
      owner_d     = owner_in;
      if_rvalid_d = (owner_q == OWN_IF);
      dm_rvalid_d = (owner_q == OWN_DM);
      // rdata only updates for its own owner and holds otherwise.
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if (owner_q == OWN_IF) begin
         if_rdata_d = mem_rdata;
      end
      if (owner_q == OWN_DM) begin
         dm_rdata_d = mem_rdata;
      end
   end

   // Reset drops both stages, so responses in flight never appear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_q     <= OWN_NONE;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         owner_q     <= owner_d;
         if_rvalid_q <= if_rvalid_d;
         dm_rvalid_q <= dm_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rvalid = dm_rvalid_q;
   assign dm_rdata  = dm_rdata_q;
   assign dbg_owner = owner_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port synchronous RAM between instruction fetch (IF) and
// the MEM-stage load/store port (DM). Data wins by default; after STARVE_MAX
// consecutive denied fetch cycles the fetch is forced ahead once, then data
// priority returns. Reads respond two cycles after the grant.
//
// Handshake: a requester raises *_req with stable fields and keeps them until
// it sees *_gnt high in the same cycle; that cycle's rising edge accepts the
// access. *_gnt is combinational from *_req and the arbiter state. *_rvalid
// pulses for one cycle with the read data and has no back-pressure.
//
// Ports:
//   clk, rst                    : clock, synchronous active-low reset
//   if_req/if_addr/if_gnt       : fetch request, address, grant
//   if_rvalid/if_rdata          : fetch response
//   dm_req/dm_we/dm_addr/dm_wdata/dm_gnt : data request and grant
//   dm_rvalid/dm_rdata          : load response (no response for stores)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : RAM port
//   fetch_stall                 : fetch requested but not granted
//   dbg_mode/dbg_starve_cnt     : arbitration state for observation
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 4
)
(
   input  logic              clk,
   input  logic              rst,
   // fetch requester
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   // data requester
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   // RAM port
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   // hazard unit
   output logic              fetch_stall,
   // observation
   output logic              dbg_mode,
   output logic [CNT_W-1:0]  dbg_starve_cnt
);

   localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);

   arb_mode_t        mode_d, mode_q;
   logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;
   logic             fetch_denied;
   rsp_owner_t       owner_now;
   rsp_owner_t       owner_pipe;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_q       <= ARB_DM;
         starve_cnt_q <= '0;
      end else begin
         mode_q       <= mode_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // ----------------------------------------------------------- next state
   assign fetch_denied = if_req & ~if_gnt;

   always_comb begin
      mode_d       = mode_q;
      starve_cnt_d = starve_cnt_q;
      if (fetch_denied) begin
         if (starve_cnt_q != STARVE_LAST) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
         end
         // The STARVE_MAX-th consecutive denial arms the forced fetch.
         if ((mode_q == ARB_DM) && (starve_cnt_q == STARVE_LAST)) begin
            mode_d = FORCE_IF;
         end
      end else begin
         // Fetch granted or no longer requesting: starvation episode is over.
         starve_cnt_d = '0;
         mode_d       = ARB_DM;
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      if_gnt    = 1'b0;
      dm_gnt    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (rst) begin
         if (mode_q == FORCE_IF) begin
            if (if_req) begin
               if_gnt = 1'b1;
            end else if (dm_req) begin
               dm_gnt = 1'b1;
            end
         end else begin
            if (dm_req) begin
               dm_gnt = 1'b1;
            end else if (if_req) begin
               if_gnt = 1'b1;
            end
         end
      end
      if (dm_gnt) begin
         mem_addr  = dm_addr;
         mem_wdata = dm_wdata;
      end else if (if_gnt) begin
         mem_addr  = if_addr;
      end
   end

   assign mem_en      = if_gnt | dm_gnt;
   assign mem_we      = dm_gnt & dm_we;
   assign fetch_stall = rst & if_req & ~if_gnt;
   assign owner_now   = rsp_owner_of(if_gnt, dm_gnt, dm_we);

   assign dbg_mode       = mode_q;
   assign dbg_starve_cnt = starve_cnt_q;

   // ------------------------------------------------------- response path
   mem_arb_rsp_pipe #(
      .DATA_W (DATA_W)
   ) u_rsp_pipe (
      .clk       (clk),
      .rst       (rst),
      .owner_in  (owner_now),
      .mem_rdata (mem_rdata),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .dbg_owner (owner_pipe)
   );

   // The in-flight owner is kept visible for waveform debug only.
   logic unused_owner;
   assign unused_owner = ^owner_pipe;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives both requesters, models the RAM, and checks grants, RAM port muxing
// and read responses against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;
   localparam int CNT_W      = 4;

   // ------------------------------------------------------- clock / reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // -------------------------------------------------------------- DUT io
   logic              if_req, if_gnt, if_rvalid;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata, dm_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              fetch_stall;
   logic              dbg_mode;
   logic [CNT_W-1:0]  dbg_starve_cnt;

   mem_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_MAX (STARVE_MAX),
      .CNT_W      (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .if_req         (if_req),
      .if_addr        (if_addr),
      .if_gnt         (if_gnt),
      .if_rvalid      (if_rvalid),
      .if_rdata       (if_rdata),
      .dm_req         (dm_req),
      .dm_we          (dm_we),
      .dm_addr        (dm_addr),
      .dm_wdata       (dm_wdata),
      .dm_gnt         (dm_gnt),
      .dm_rvalid      (dm_rvalid),
      .dm_rdata       (dm_rdata),
      .mem_en         (mem_en),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .fetch_stall    (fetch_stall),
      .dbg_mode       (dbg_mode),
      .dbg_starve_cnt (dbg_starve_cnt)
   );

   // ----------------------------------------------------------- RAM model
   logic [DATA_W-1:0] ram [0:255];
   logic              bk_we;
   logic [7:0]        bk_idx;
   logic [DATA_W-1:0] bk_data;

   always @(posedge clk) begin
      if (bk_we) begin
         ram[bk_idx] <= bk_data;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr[9:2]];
      end
   end

   // --------------------------------------------------- reference model
   logic [DATA_W-1:0] ref_mem [0:255];
   int                denied;          // consecutive cycles fetch was refused
   logic [63:0]       exp_if_q[$];     // {cycle rvalid is due, data}
   logic [63:0]       exp_dm_q[$];

   int total = 0;
   int bad   = 0;

   function automatic void cmp(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // One cycle: apply inputs after the edge, then check the combinational
   // response against the model and book the expected read responses.
   task automatic apply(input logic r, input logic ireq, input logic [31:0] iaddr,
                        input logic dreq, input logic dwe, input logic [31:0] daddr,
                        input logic [31:0] dwd, output logic gi, output logic gd);
      logic ei, ed;
      logic [31:0] ea, ew;
      @(posedge clk);
      #1;
      rst = r; if_req = ireq; if_addr = iaddr;
      dm_req = dreq; dm_we = dwe; dm_addr = daddr; dm_wdata = dwd;
      #2;
      ei = 1'b0; ed = 1'b0;
      if (rst) begin
         if (if_req && denied >= STARVE_MAX) ei = 1'b1;
         else if (dm_req)                    ed = 1'b1;
         else if (if_req)                    ei = 1'b1;
      end
      ea = ed ? dm_addr : (ei ? if_addr : 32'h0);
      ew = ed ? dm_wdata : 32'h0;
      cmp("if_gnt",      64'(if_gnt),      64'(ei));
      cmp("dm_gnt",      64'(dm_gnt),      64'(ed));
      cmp("mem_en",      64'(mem_en),      64'(ei | ed));
      cmp("mem_we",      64'(mem_we),      64'(ed & dm_we));
      cmp("mem_addr",    64'(mem_addr),    64'(ea));
      cmp("mem_wdata",   64'(mem_wdata),   64'(ew));
      cmp("fetch_stall", 64'(fetch_stall), 64'(rst & if_req & ~ei));
      if (rst) begin
         cmp("dbg_mode",       64'(dbg_mode),       64'(denied >= STARVE_MAX));
         cmp("dbg_starve_cnt", 64'(dbg_starve_cnt),
             64'((denied < STARVE_MAX) ? denied : STARVE_MAX - 1));
      end
      if (!rst) begin
         denied = 0;
         exp_if_q.delete();
         exp_dm_q.delete();
      end else begin
         if (if_req && !ei) denied++;
         else               denied = 0;
         if (ei)           exp_if_q.push_back({32'(cyc + 2), ref_mem[if_addr[9:2]]});
         if (ed && !dm_we) exp_dm_q.push_back({32'(cyc + 2), ref_mem[dm_addr[9:2]]});
         if (ed && dm_we)  ref_mem[dm_addr[9:2]] = dm_wdata;
      end
      gi = ei;
      gd = ed;
   endtask

   task automatic idle(input int n);
      logic gi, gd;
      for (int k = 0; k < n; k++) apply(1'b1, 1'b0, 32'($urandom), 1'b0, 1'b0,
                                        32'($urandom), 32'($urandom), gi, gd);
   endtask

   // ------------------------------------------------------------- monitor
   task automatic monitor_loop();
      logic [31:0] last_if, last_dm;
      logic        rst_prev;
      logic [63:0] e;
      last_if = '0; last_dm = '0; rst_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            // A reset edge has already passed: nothing may be presented.
            if (!rst_prev) begin
               cmp("rvalid_in_reset", 64'({if_rvalid, dm_rvalid}), 64'd0);
               cmp("rdata_in_reset",  64'({if_rdata, dm_rdata}),   64'd0);
            end
            last_if = '0; last_dm = '0;
         end else begin
            cmp("both_rvalid", 64'(if_rvalid & dm_rvalid), 64'd0);
            if (if_rvalid) begin
               if (exp_if_q.size() == 0) begin
                  cmp("if_rvalid_unexpected", 64'(if_rvalid), 64'd0);
               end else begin
                  e = exp_if_q.pop_front();
                  cmp("if_rvalid_cycle", 64'(cyc), 64'(e[63:32]));
                  cmp("if_rdata",        64'(if_rdata), 64'(e[31:0]));
                  last_if = e[31:0];
               end
            end else begin
               cmp("if_rdata_hold", 64'(if_rdata), 64'(last_if));
            end
            if (dm_rvalid) begin
               if (exp_dm_q.size() == 0) begin
                  cmp("dm_rvalid_unexpected", 64'(dm_rvalid), 64'd0);
               end else begin
                  e = exp_dm_q.pop_front();
                  cmp("dm_rvalid_cycle", 64'(cyc), 64'(e[63:32]));
                  cmp("dm_rdata",        64'(dm_rdata), 64'(e[31:0]));
                  last_dm = e[31:0];
               end
            end else begin
               cmp("dm_rdata_hold", 64'(dm_rdata), 64'(last_dm));
            end
         end
         rst_prev = rst;
      end
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      logic        gi, gd, pi, pd, pdwe;
      logic [6:0]  pat;
      logic [31:0] v, pia, pda, pdw;

      rst = 1'b0; if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      bk_we = 1'b0; bk_idx = '0; bk_data = '0;
      denied = 0;
      fork
         monitor_loop();
      join_none

      // Long reset with both requests high; RAM preloaded meanwhile.
      for (int i = 0; i < 64; i++) begin
         v = (i < 3) ? 32'h11 * 32'(i + 1) : $urandom;
         ref_mem[i] = v;
         bk_we = 1'b1; bk_idx = 8'(i); bk_data = v;
         apply(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h44, 32'h0, gi, gd);
      end
      bk_we = 1'b0;

      // Release with both requesting continuously: data first, fetch starves.
      pia = 32'h0C; pda = 32'h80;
      for (int c = 0; c < 7; c++) begin
         apply(1'b1, 1'b1, pia, 1'b1, 1'b0, pda, 32'h0, gi, gd);
         pat[c] = if_gnt;
         if (gi) pia = pia + 32'h4;
         if (gd) pda = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
      end
      cmp("starve_pattern", 64'(pat), 64'(7'b0010000));
      idle(3);

      // Fetch-only burst.
      for (int c = 0; c < 3; c++) apply(1'b1, 1'b1, 32'(4 * c), 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
      idle(3);

      // Store then load of the same word.
      apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, gi, gd);
      apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, gi, gd);
      idle(3);

      // Alternating fetch / load grants.
      for (int c = 0; c < 4; c++) begin
         apply(1'b1, 1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0, gi, gd);
         apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, gi, gd);
      end
      idle(3);

      // Reset while a load is in flight.
      apply(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, gi, gd);
      for (int c = 0; c < 3; c++) apply(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, gi, gd);
      idle(3);

      // Random traffic obeying the hold-until-grant protocol.
      pi = 1'b0; pd = 1'b0; pdwe = 1'b0; pia = '0; pda = '0; pdw = '0;
      for (int k = 0; k < 400; k++) begin
         if (!pi) begin
            pi  = ($urandom_range(0, 3) != 0);
            pia = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         end
         if (!pd) begin
            pd   = ($urandom_range(0, 2) != 0);
            pdwe = ($urandom_range(0, 2) == 0);
            pda  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            pdw  = $urandom;
         end
         apply(1'b1, pi, pia, pd, pdwe, pda, pdw, gi, gd);
         if (gi) pi = 1'b0;
         if (gd) pd = 1'b0;
      end
      for (int k = 0; k < 20 && (pi || pd); k++) begin
         apply(1'b1, pi, pia, pd, pdwe, pda, pdw, gi, gd);
         if (gi) pi = 1'b0;
         if (gd) pd = 1'b0;
      end
      cmp("drain", 64'({pi, pd}), 64'd0);
      idle(4);

      cmp("if_q_empty", 64'(exp_if_q.size()), 64'd0);
      cmp("dm_q_empty", 64'(exp_dm_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
